// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the fetch stage control inputs, instruction-memory
//               bus, IF/ID register outputs and performance counters.
//               'master' is the pipeline/memory side, 'slave' the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
  parameter int CNT_W = 32
);

  // Control from hazard unit and ID stage
  logic             start_i;
  logic             stall_i;
  logic             branch_i;
  logic [31:0]      branch_target_i;
  logic             jump_i;
  logic [31:0]      jump_target_i;

  // Instruction memory bus
  logic [31:0]      imem_addr_o;
  logic [31:0]      imem_data_i;

  // PC and IF/ID register
  logic [31:0]      pc_o;
  logic [31:0]      if_id_pc4_o;
  logic [31:0]      if_id_inst_o;
  logic             if_id_valid_o;
  logic             flush_o;
  logic             fetch_err_o;

  // Performance counters
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, stall_i, branch_i, branch_target_i, jump_i, jump_target_i,
    output imem_data_i,
    input  imem_addr_o, pc_o, if_id_pc4_o, if_id_inst_o, if_id_valid_o,
    input  flush_o, fetch_err_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, stall_i, branch_i, branch_target_i, jump_i, jump_target_i,
    input  imem_data_i,
    output imem_addr_o, pc_o, if_id_pc4_o, if_id_inst_o, if_id_valid_o,
    output flush_o, fetch_err_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : MIPS instruction-fetch stage. Owns the PC, addresses
//               instruction memory, loads the IF/ID register, applies
//               hazard stall and ID-stage branch/jump redirect, and keeps
//               saturating cycle/stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0,
  parameter int          IMEM_DEPTH = 256,
  parameter int          CNT_W      = 32     // must match the interface CNT_W
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,               // asynchronous, active low
  fetch_unit_if.slave   bus
);

  localparam logic [31:0]      C_PC_STEP = 32'd4;
  localparam logic [31:0]      C_NOP     = 32'h0;
  localparam logic [31:0]      C_DEPTH   = 32'($unsigned(IMEM_DEPTH));
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // One action per cycle, listed in priority order
  typedef enum logic [2:0] {
    ACT_IDLE   = 3'd0,
    ACT_STALL  = 3'd1,
    ACT_BRANCH = 3'd2,
    ACT_JUMP   = 3'd3,
    ACT_RUN    = 3'd4
  } act_t;

  act_t             w_act;
  logic [31:0]      w_pc_plus4;
  logic             w_in_range;
  logic [31:0]      w_fetch_word;
  logic             w_flush;

  logic [31:0]      r_pc;
  logic [31:0]      r_if_id_pc4;
  logic [31:0]      r_if_id_inst;
  logic             r_if_id_valid;
  logic             r_fetch_err;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + C_CNT_ONE);
  endfunction

  // Select this cycle's action; stall wins over redirect because the
  // branch operands are not yet valid while the hazard unit holds ID
  always_comb begin
    w_act = ACT_RUN;
    if (!bus.start_i)       w_act = ACT_IDLE;
    else if (bus.stall_i)   w_act = ACT_STALL;
    else if (bus.branch_i)  w_act = ACT_BRANCH;
    else if (bus.jump_i)    w_act = ACT_JUMP;
  end

  // Sequential PC (wraps modulo 2^32) and range-checked fetched word;
  // low address bits are ignored for word indexing
  always_comb begin
    w_pc_plus4   = r_pc + C_PC_STEP;
    w_in_range   = ({2'b00, r_pc[31:2]} < C_DEPTH);
    w_fetch_word = w_in_range ? bus.imem_data_i : C_NOP;
    w_flush      = bus.start_i & ~bus.stall_i & (bus.branch_i | bus.jump_i);
  end

  // PC, IF/ID register and sticky fetch error
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc          <= PC_RESET;
      r_if_id_pc4   <= 32'h0;
      r_if_id_inst  <= C_NOP;
      r_if_id_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      case (w_act)
        ACT_IDLE: begin
          r_if_id_pc4   <= 32'h0;
          r_if_id_inst  <= C_NOP;
          r_if_id_valid <= 1'b0;
        end
        ACT_STALL: begin
          // PC and IF/ID hold
        end
        ACT_BRANCH: begin
          r_pc          <= bus.branch_target_i;
          r_if_id_pc4   <= 32'h0;
          r_if_id_inst  <= C_NOP;
          r_if_id_valid <= 1'b0;
        end
        ACT_JUMP: begin
          r_pc          <= bus.jump_target_i;
          r_if_id_pc4   <= 32'h0;
          r_if_id_inst  <= C_NOP;
          r_if_id_valid <= 1'b0;
        end
        default: begin
          // An out-of-range fetch still loads a valid NOP so the pipeline
          // keeps its slot accounting; the error flag records the event
          r_pc          <= w_pc_plus4;
          r_if_id_pc4   <= w_pc_plus4;
          r_if_id_inst  <= w_fetch_word;
          r_if_id_valid <= 1'b1;
          if (!w_in_range) begin
            r_fetch_err <= 1'b1;
          end
        end
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.start_i) begin
        r_cycle_cnt <= sat_inc(r_cycle_cnt);
      end
      if (w_act == ACT_STALL) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if ((w_act == ACT_BRANCH) || (w_act == ACT_JUMP)) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end
    end
  end

  assign bus.imem_addr_o   = r_pc;
  assign bus.pc_o          = r_pc;
  assign bus.if_id_pc4_o   = r_if_id_pc4;
  assign bus.if_id_inst_o  = r_if_id_inst;
  assign bus.if_id_valid_o = r_if_id_valid;
  assign bus.flush_o       = w_flush;
  assign bus.fetch_err_o   = r_fetch_err;
  assign bus.cycle_cnt_o   = r_cycle_cnt;
  assign bus.stall_cnt_o   = r_stall_cnt;
  assign bus.flush_cnt_o   = r_flush_cnt;

endmodule

`default_nettype wire
